i_buf_en_sequencer: RTL

//  Power-up/enable sequencer for a bank of NUM_BUF I_BUF primitives. Drives their EN pins one

---
 rtl/i_buf_en_sequencer_if.sv | 12 +
 rtl/i_buf_en_sequencer.sv | 86 ++++++++
 2 files changed

// File: rtl/i_buf_en_sequencer_if.sv
// i_buf_en_sequencer_if: request/buffer-bank bundle between fabric, sequencer and I_BUF wrapper
interface i_buf_en_sequencer_if #(parameter int NUM_BUF = 8);
  logic REQ_EN;
  logic [NUM_BUF-1:0] BUF_O;
  logic [NUM_BUF-1:0] EN;
  logic [NUM_BUF-1:0] DATA_OUT;
  logic DATA_VALID;
  logic READY;
  logic BUSY;
  modport master (output REQ_EN, BUF_O, input EN, DATA_OUT, DATA_VALID, READY, BUSY);
  modport slave (input REQ_EN, BUF_O, output EN, DATA_OUT, DATA_VALID, READY, BUSY);
endinterface

// File: rtl/i_buf_en_sequencer.sv
// i_buf_en_sequencer: enables an I_BUF bank one buffer per settle window and masks unsettled data
module i_buf_en_sequencer #(
  parameter int NUM_BUF = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input logic CLK,
  input logic RST,
  i_buf_en_sequencer_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int IW = NUM_BUF > 1 ? $clog2(NUM_BUF) : 1;
  typedef enum logic [1:0] {IDLE, SETTLE, ACTIVE, SHUTDOWN} state_t;
  state_t state_q, state_d;
  logic [NUM_BUF-1:0] en_q, en_d, settled_q, settled_d, data_out_q;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ready_q, ready_d, busy_q, busy_d, data_valid_q;
  always_comb begin
    state_d = state_q;
    en_d = en_q;
    settled_d = settled_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (bus.REQ_EN) begin
        en_d = NUM_BUF'(1);
        idx_d = '0;
        cnt_d = CW'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
    end else if (state_q == SHUTDOWN) begin
      cnt_d = cnt_q == '0 ? '0 : cnt_q - CW'(1);
      state_d = cnt_q == '0 ? IDLE : SHUTDOWN;
    end else if (!bus.REQ_EN) begin
      en_d = '0;
      settled_d = '0;
      idx_d = '0;
      cnt_d = CW'(SETTLE_CYCLES - 1);
      state_d = SHUTDOWN;
    end else if (state_q == SETTLE) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end else begin
        // EN and SETTLED are thermometers, so setting bit idx (+1) is a shift-in of a one
        settled_d = (settled_q << 1) | NUM_BUF'(1);
        if (idx_q != IW'(NUM_BUF - 1)) begin
          en_d = (en_q << 1) | NUM_BUF'(1);
          idx_d = idx_q + IW'(1);
          cnt_d = CW'(SETTLE_CYCLES - 1);
        end else begin
          state_d = ACTIVE;
        end
      end
    end
    ready_d = state_d == ACTIVE;
    busy_d = state_d == SETTLE || state_d == SHUTDOWN;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      en_q <= '0;
      settled_q <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      ready_q <= 1'b0;
      busy_q <= 1'b0;
      data_out_q <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q <= en_d;
      settled_q <= settled_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      ready_q <= ready_d;
      busy_q <= busy_d;
      data_out_q <= bus.BUF_O & settled_q;
      data_valid_q <= &settled_q;
    end
  end
  assign bus.EN = en_q;
  assign bus.DATA_OUT = data_out_q;
  assign bus.DATA_VALID = data_valid_q;
  assign bus.READY = ready_q;
  assign bus.BUSY = busy_q;
endmodule
